riscv_mem_responder: RTL and testbench

Single-port memory responder on the RISC-V core's data bus. It accepts one load or store request at a time through a valid/ready handshake and serves it from an internal word array after a configurable number of wait states. It returns read data or an error response through a second valid/ready handshake. Illegal accesses are flagged with `rsp_error`, which the core converts into a load/store access-fault trap. The internal array is named `mem` so benches can preload it hierarchically with `$readmemh`.

---
 rtl/riscv_mem_responder.sv | 109 ++++++++++
 tb/tb_riscv_mem_responder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_responder.sv
// Single-outstanding load/store responder for the core data bus. Serves requests
// from the internal word array `mem` after WAIT_STATES cycles and flags faults.
module riscv_mem_responder #(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int          AW   = $clog2(MEM_WORDS);
  localparam logic [32:0] SPAN = 33'(MEM_WORDS) * 33'd4;
  localparam logic [3:0]  WS4  = 4'(WAIT_STATES);

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  req_t        req_q, req_in, ex;
  logic [3:0]  cnt_q;
  logic        accept, exec, ex_err;
  logic [31:0] off;
  logic [AW-1:0] idx;

  logic [31:0] mem [MEM_WORDS];

  assign req_in    = {req_addr, req_write, req_wdata, req_wstrb};
  assign req_ready = (state_q == IDLE) && !reset;
  assign rsp_valid = (state_q == RESP);
  assign accept    = req_valid && req_ready;

  // With zero wait states the access executes on the accept edge, straight from the bus.
  assign ex     = (state_q == IDLE) ? req_in : req_q;
  assign off    = ex.addr - BASE_ADDR;
  assign ex_err = (ex.addr[1:0] != 2'b00) || (ex.addr < BASE_ADDR) || ({1'b0, off} >= SPAN);
  assign idx    = off[AW+1:2];

  always_comb begin
    state_d = state_q;
    exec    = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (WAIT_STATES == 0) begin
          state_d = RESP;
          exec    = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: if (cnt_q == 4'd1) begin
        state_d = RESP;
        exec    = 1'b1;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      req_q     <= '0;
      cnt_q     <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_error <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q <= req_in;
        cnt_q <= WS4;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (exec) begin
        rsp_error <= ex_err;
        rsp_rdata <= (ex_err || ex.write) ? 32'd0 : mem[idx];
      end else if (state_q == RESP && rsp_ready) begin
        rsp_error <= 1'b0;
        rsp_rdata <= 32'd0;
      end
    end
  end

  // Array is deliberately not reset; a store commits only on the execute edge.
  always_ff @(posedge clk) begin
    if (exec && ex.write && !ex_err) begin
      for (int i = 0; i < 4; i++)
        if (ex.wstrb[i]) mem[idx][8*i +: 8] <= ex.wdata[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Directed bench: u0 runs with one wait state, u1 with three; `sel` routes the shared bus.
module tb_riscv_mem_responder;

  logic        clk = 1'b0;
  logic        rst0 = 1'b1, rst1 = 1'b1, sel = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;

  logic        rdy0, rdy1, vld0, vld1, err0, err1;
  logic [31:0] rd0, rd1;
  logic        req_ready, rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;

  int n_cmp = 0, n_bad = 0;

  riscv_mem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u0 (
    .clk(clk), .reset(rst0), .req_valid(req_valid && !sel), .req_ready(rdy0),
    .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(vld0), .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_error(err0));

  riscv_mem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u1 (
    .clk(clk), .reset(rst1), .req_valid(req_valid && sel), .req_ready(rdy1),
    .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(vld1), .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_error(err1));

  assign req_ready = sel ? rdy1 : rdy0;
  assign rsp_valid = sel ? vld1 : vld0;
  assign rsp_rdata = sel ? rd1  : rd0;
  assign rsp_error = sel ? err1 : err0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // One full transaction with rsp_ready held high; bus fields are scrambled after accept.
  task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, input int exp_lat,
                     output logic [31:0] rd, output logic er);
    int lat = 0;
    @(negedge clk);
    req_addr = a; req_write = w; req_wdata = d; req_wstrb = s; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = ~a; req_write = ~w; req_wdata = ~d; req_wstrb = ~s;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    rd = rsp_rdata;
    er = rsp_error;
    @(posedge clk); #1;
    chk("post_rsp_ready", req_ready, 1'b1);
    chk("post_rsp_valid", rsp_valid, 1'b0);
  endtask

  logic [31:0] rd;
  logic        er;
  logic        seen;

  initial begin
    u0.mem[0] = 32'hCAFE_F00D;
    u0.mem[2] = 32'h1122_3344;
    u0.mem[4] = 32'hDEAD_BEEF;
    u1.mem[8] = 32'h55AA_55AA;

    #12;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    #5 rst0 = 1'b0; rst1 = 1'b0;
    #1;
    chk("rel_req_ready", req_ready, 1'b1);
    chk("rel_rsp_valid", rsp_valid, 1'b0);

    txn(32'h10, 1'b0, 32'h0, 4'h0, 1, rd, er);
    chk("ld10_data", rd, 32'hDEAD_BEEF);
    chk("ld10_err", er, 1'b0);

    txn(32'h08, 1'b1, 32'hAABB_CCDD, 4'b0101, 1, rd, er);
    chk("st08_data", rd, 32'h0);
    chk("st08_err", er, 1'b0);
    txn(32'h08, 1'b0, 32'h0, 4'h0, 1, rd, er);
    chk("ld08_merged", rd, 32'h11BB_33DD);

    txn(32'h02, 1'b0, 32'h0, 4'h0, 1, rd, er);
    chk("ld_misalign_err", er, 1'b1);
    chk("ld_misalign_data", rd, 32'h0);

    txn(32'h1000, 1'b1, 32'h0BAD_0BAD, 4'hF, 1, rd, er);
    chk("st_oob_err", er, 1'b1);
    chk("st_oob_mem0", u0.mem[0], 32'hCAFE_F00D);

    txn(32'h10, 1'b1, 32'h0, 4'b0000, 1, rd, er);
    chk("st_nostrb_err", er, 1'b0);
    txn(32'h10, 1'b0, 32'h0, 4'h0, 1, rd, er);
    chk("st_nostrb_keep", rd, 32'hDEAD_BEEF);

    txn(32'hFFFF_FFFC, 1'b0, 32'h0, 4'h0, 1, rd, er);
    chk("ld_top_err", er, 1'b1);

    // Async reset while a faulting response is parked.
    rsp_ready = 1'b0;
    @(negedge clk); req_addr = 32'h2; req_write = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", rsp_valid, 1'b1);
    chk("pre_rst_error", rsp_error, 1'b1);
    #2 rst0 = 1'b1;
    #1;
    chk("async_req_ready", req_ready, 1'b0);
    chk("async_rsp_valid", rsp_valid, 1'b0);
    chk("async_rsp_error", rsp_error, 1'b0);
    @(negedge clk); rst0 = 1'b0;
    #1 chk("rst_rel_ready", req_ready, 1'b1);
    @(posedge clk); #1 chk("rst_rel_novalid", rsp_valid, 1'b0);

    // Backpressure: response held 5 cycles, an intruding request must be ignored.
    @(negedge clk); req_addr = 32'h10; req_write = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = (i == 1); req_addr = 32'h08;
      #1;
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("bp_error", rsp_error, 1'b0);
      chk("bp_req_ready", req_ready, 1'b0);
    end
    @(negedge clk); req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_done_valid", rsp_valid, 1'b0);
    chk("bp_done_ready", req_ready, 1'b1);
    @(posedge clk); #1 chk("bp_no_extra", rsp_valid, 1'b0);

    // Three-wait-state instance.
    sel = 1'b1;
    txn(32'h20, 1'b0, 32'h0, 4'h0, 3, rd, er);
    chk("u1_ld20", rd, 32'h55AA_55AA);

    @(negedge clk); req_addr = 32'h20; req_write = 1'b1; req_wdata = 32'h1234_5678;
    req_wstrb = 4'hF; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #3 rst1 = 1'b1;
    #1 chk("u1_rst_ready", req_ready, 1'b0);
    @(negedge clk); rst1 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk("u1_dropped_rsp", seen, 1'b0);
    chk("u1_mem8_kept", u1.mem[8], 32'h55AA_55AA);
    chk("u1_ready_after", req_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
